// File: rtl/uart_transmit_fifo.sv
// UART transmitter with an input FIFO: configurable data width, parity and stop bits.
// Frames leave back-to-back with no idle gap while the FIFO holds words.
module uart_transmit_fifo #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          busy_out,
    output logic                          tx_wire_out
);
    localparam int BAUD_DIV = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int BIT_W    = 4;

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_transmit_fifo: BAUD_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_transmit_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_transmit_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_transmit_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_transmit_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_next;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_end;
    logic                 w_tx_next;
    logic                 w_shift_en;
    logic                 w_bit_clr;
    logic                 w_bit_inc;
    logic [DATA_BITS-1:0] w_head;

    assign ready_out      = (r_count != CNT_W'(FIFO_DEPTH));
    assign fifo_count_out = r_count;
    assign busy_out       = r_busy;
    assign tx_wire_out    = r_tx;

    assign w_push     = valid_in && ready_out;
    assign w_baud_end = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = r_tx;
        w_shift_en   = 1'b0;
        w_bit_clr    = 1'b0;
        w_bit_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_tx_next    = r_shift[0];
                    w_shift_en   = 1'b1;
                    w_bit_clr    = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        w_bit_clr = 1'b1;
                        if (PARITY != 0) begin
                            w_tx_next    = r_par;
                            w_state_next = S_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_tx_next  = r_shift[0];
                        w_shift_en = 1'b1;
                        w_bit_inc  = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_tx_next    = 1'b1;
                    w_bit_clr    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        // Next word's start bit follows the last stop cycle directly.
                        if (r_count != '0) begin
                            w_pop        = 1'b1;
                            w_tx_next    = 1'b0;
                            w_state_next = S_START;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            if (w_pop || w_baud_end || r_state == S_IDLE) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != S_IDLE) || (w_count_next != '0);
        end
    end

    // Payload storage carries no reset; only control state is cleared.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
        if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (PARITY == 2) ? ~^w_head : ^w_head;
        end else if (w_shift_en) begin
            r_shift <= r_shift >> 1;
        end
    end

endmodule
